rx_bad_frame_filter: RTL

- Store-and-forward packet buffer directly downstream of the RX AXI-MAC converter.
- Accepts the converter's AXI stream plus a per-frame error flag.
- Forwards only complete, good frames; silently discards bad frames and frames that overflow the buffer.
- Upstream is never backpressured, so the MAC-side FIFO cannot back up because of this stage.

---
 rtl/rx_bad_frame_filter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rx_bad_frame_filter.sv
// Store-and-forward RX buffer: forwards only complete good frames; bad or overflowing frames are rolled back.
// Optional build macro RX_DROP_STATS_EN adds good/bad/overflow frame counters.
module rx_bad_frame_filter #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_terr,
    output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
`ifdef RX_DROP_STATS_EN
    ,
    output logic [31:0]                 good_pkt_cnt,
    output logic [31:0]                 bad_pkt_cnt,
    output logic [31:0]                 ovf_pkt_cnt
`endif
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int ENT_W  = 1 + STRB_W + AXI_DATA_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef enum logic {WR_PKT, WR_DISCARD} wr_state_t;

    wr_state_t        wr_state;
    ptr_t             wr_ptr, commit_ptr, rd_ptr;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] ram_q, skid_q, out_q;
    logic             rd_vld, skid_vld;
    logic             accept, full, wr_en, rd_en, pop;
    logic [1:0]       occ;

    assign accept = s_axis_tvalid & s_axis_tready;
    // rd_ptr is the registered value, so full ignores any read issued this cycle
    assign full   = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
    assign wr_en  = accept && (wr_state == WR_PKT) && !full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axis_tready <= 1'b0;
            wr_state      <= WR_PKT;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
`ifdef RX_DROP_STATS_EN
            good_pkt_cnt  <= '0;
            bad_pkt_cnt   <= '0;
            ovf_pkt_cnt   <= '0;
`endif
        end else begin
            s_axis_tready <= 1'b1;
            if (accept) begin
                case (wr_state)
                    WR_PKT: begin
                        if (!full) begin
                            if (s_axis_tlast && s_axis_terr) begin
                                wr_ptr <= commit_ptr;
`ifdef RX_DROP_STATS_EN
                                bad_pkt_cnt <= bad_pkt_cnt + 32'd1;
`endif
                            end else if (s_axis_tlast) begin
                                wr_ptr     <= wr_ptr + ptr_t'(1);
                                commit_ptr <= wr_ptr + ptr_t'(1);
`ifdef RX_DROP_STATS_EN
                                good_pkt_cnt <= good_pkt_cnt + 32'd1;
`endif
                            end else begin
                                wr_ptr <= wr_ptr + ptr_t'(1);
                            end
                        end else begin
                            wr_ptr <= commit_ptr;
                            if (s_axis_tlast) begin
`ifdef RX_DROP_STATS_EN
                                ovf_pkt_cnt <= ovf_pkt_cnt + 32'd1;
`endif
                            end else begin
                                wr_state <= WR_DISCARD;
                            end
                        end
                    end
                    WR_DISCARD: begin
                        if (s_axis_tlast) begin
                            wr_state <= WR_PKT;
`ifdef RX_DROP_STATS_EN
                            ovf_pkt_cnt <= ovf_pkt_cnt + 32'd1;
`endif
                        end
                    end
                    default: wr_state <= WR_PKT;
                endcase
            end
        end
    end

    // Read credit: output reg + skid + in-flight RAM read never exceed two beats
    assign pop   = m_axis_tvalid & m_axis_tready;
    assign occ   = {1'b0, m_axis_tvalid} + {1'b0, skid_vld} + {1'b0, rd_vld};
    assign rd_en = (rd_ptr != commit_ptr) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
        if (rd_en)
            ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr        <= '0;
            rd_vld        <= 1'b0;
            skid_vld      <= 1'b0;
            skid_q        <= '0;
            out_q         <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en)
                rd_ptr <= rd_ptr + ptr_t'(1);
            if (!m_axis_tvalid || pop) begin
                if (skid_vld) begin
                    out_q         <= skid_q;
                    m_axis_tvalid <= 1'b1;
                    skid_vld      <= rd_vld;
                    if (rd_vld)
                        skid_q <= ram_q;
                end else if (rd_vld) begin
                    out_q         <= ram_q;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end else if (rd_vld) begin
                skid_q   <= ram_q;
                skid_vld <= 1'b1;
            end
        end
    end

    assign m_axis_tlast = out_q[ENT_W-1];
    assign m_axis_tstrb = out_q[AXI_DATA_WIDTH +: STRB_W];
    assign m_axis_tdata = out_q[AXI_DATA_WIDTH-1:0];

endmodule
